// File: rtl/ysyx_22051013_idu_pipe.sv
// Registered RV32/RV64 decode stage: valid/ready on both sides, output register plus
// one-entry skid buffer, sticky halt on ebreak, and pipeline flush.
`default_nettype none

module ysyx_22051013_idu_pipe #(
   parameter int XLEN = 64,
   parameter int RV_M = 1,
   parameter int PC_W = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [PC_W-1:0] in_pc,
   input  logic [31:0]     in_inst,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   output logic [4:0]      rd_addr,
   output logic            rs1_ena,
   output logic            rs2_ena,
   output logic            rd_ena,
   output logic [XLEN-1:0] imm,
   output logic            imm_ena,
   output logic [3:0]      alu_op,
   output logic            alu_word,
   output logic            alu_mul,
   output logic [3:0]      mem_ctl,
   output logic [1:0]      wb_ctl,
   output logic            branch,
   output logic            jump,
   output logic            is_ebreak,
   output logic            illegal,
   output logic            halted
);

   localparam logic [4:0]  OPC_LOAD   = 5'b00000;
   localparam logic [4:0]  OPC_OPIMM  = 5'b00100;
   localparam logic [4:0]  OPC_AUIPC  = 5'b00101;
   localparam logic [4:0]  OPC_OPIMM32= 5'b00110;
   localparam logic [4:0]  OPC_STORE  = 5'b01000;
   localparam logic [4:0]  OPC_OP     = 5'b01100;
   localparam logic [4:0]  OPC_LUI    = 5'b01101;
   localparam logic [4:0]  OPC_OP32   = 5'b01110;
   localparam logic [4:0]  OPC_BRANCH = 5'b11000;
   localparam logic [4:0]  OPC_JALR   = 5'b11001;
   localparam logic [4:0]  OPC_JAL    = 5'b11011;
   localparam logic [4:0]  OPC_SYSTEM = 5'b11100;
   localparam logic [31:0] EBREAK     = 32'h0010_0073;
   localparam bit          RV32       = (XLEN == 32);
   localparam bit          HAS_M      = (RV_M != 0);

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic            rs1_ena;
      logic            rs2_ena;
      logic            rd_ena;
      logic [XLEN-1:0] imm;
      logic            imm_ena;
      logic [3:0]      alu_op;
      logic            alu_word;
      logic            alu_mul;
      logic [3:0]      mem_ctl;
      logic [1:0]      wb_ctl;
      logic            branch;
      logic            jump;
      logic            is_ebreak;
      logic            illegal;
   } bundle_t;

   // ---------------- decode ----------------
   bundle_t     dec;
   logic [4:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic        std;
   logic        is_load, is_opimm, is_auipc, is_opimm32, is_store, is_op;
   logic        is_lui, is_op32, is_branch, is_jalr, is_jal, is_sys;
   logic        known, is_m, bad;
   logic [63:0] imm64;
   logic [3:0]  ld_code, st_code;
   logic        ld_bad, st_bad;

   always_comb begin
      opc        = in_inst[6:2];
      f3         = in_inst[14:12];
      f7         = in_inst[31:25];
      std        = (in_inst[1:0] == 2'b11);
      is_load    = std && opc == OPC_LOAD;
      is_opimm   = std && opc == OPC_OPIMM;
      is_auipc   = std && opc == OPC_AUIPC;
      is_opimm32 = std && opc == OPC_OPIMM32;
      is_store   = std && opc == OPC_STORE;
      is_op      = std && opc == OPC_OP;
      is_lui     = std && opc == OPC_LUI;
      is_op32    = std && opc == OPC_OP32;
      is_branch  = std && opc == OPC_BRANCH;
      is_jalr    = std && opc == OPC_JALR;
      is_jal     = std && opc == OPC_JAL;
      is_sys     = std && opc == OPC_SYSTEM;
      known      = is_load | is_opimm | is_auipc | is_opimm32 | is_store | is_op |
                   is_lui | is_op32 | is_branch | is_jalr | is_jal | is_sys;
      is_m       = (is_op | is_op32) && f7 == 7'b0000001;

      ld_code = 4'b0000;
      ld_bad  = 1'b0;
      case (f3)
         3'd0: ld_code = 4'b1001;
         3'd1: ld_code = 4'b1010;
         3'd2: ld_code = 4'b1011;
         3'd3: begin ld_code = 4'b1100; ld_bad = RV32; end
         3'd4: ld_code = 4'b1101;
         3'd5: ld_code = 4'b1110;
         3'd6: begin ld_code = 4'b1111; ld_bad = RV32; end
         default: ld_bad = 1'b1;
      endcase

      st_code = 4'b0000;
      st_bad  = 1'b0;
      case (f3)
         3'd0: st_code = 4'b0001;
         3'd1: st_code = 4'b0010;
         3'd2: st_code = 4'b0100;
         3'd3: begin st_code = 4'b0101; st_bad = RV32; end
         default: st_bad = 1'b1;
      endcase

      bad = !known
         || (is_load && ld_bad)
         || (is_store && st_bad)
         || (is_branch && (f3 == 3'd2 || f3 == 3'd3))
         || (RV32 && (is_op32 || is_opimm32))
         || (RV32 && is_opimm && (f3 == 3'd1 || f3 == 3'd5) && in_inst[25])
         || (!HAS_M && is_m)
         || (is_sys && in_inst != EBREAK);

      imm64 = '0;
      if (is_load || is_opimm || is_opimm32 || is_jalr || is_sys)
         imm64 = {{52{in_inst[31]}}, in_inst[31:20]};
      else if (is_store)
         imm64 = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      else if (is_branch)
         imm64 = {{51{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      else if (is_lui || is_auipc)
         imm64 = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
      else if (is_jal)
         imm64 = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

      dec           = '0;
      dec.pc        = in_pc;
      dec.rs1       = in_inst[19:15];
      dec.rs2       = in_inst[24:20];
      dec.rd        = in_inst[11:7];
      dec.rs1_ena   = known && !(is_lui || is_auipc || is_jal || is_sys);
      dec.rs2_ena   = is_op || is_op32 || is_branch || is_store;
      dec.imm       = imm64[XLEN-1:0];
      dec.imm_ena   = is_load || is_store || is_opimm || is_opimm32 || is_lui || is_auipc || is_jalr;
      dec.alu_word  = is_op32 || is_opimm32;
      dec.alu_mul   = is_m && HAS_M;
      dec.is_ebreak = (in_inst == EBREAK);
      dec.illegal   = bad;

      // Address-generating and link-writing classes all use a plain add.
      if (is_load || is_store || is_lui || is_auipc || is_jal || is_jalr)
         dec.alu_op = 4'b0000;
      else if (is_op || is_op32 || ((is_opimm || is_opimm32) && f3 == 3'd5))
         dec.alu_op = {in_inst[30], f3};
      else
         dec.alu_op = {1'b0, f3};

      if (!bad) begin
         dec.rd_ena  = (is_load || is_opimm || is_opimm32 || is_op || is_op32 ||
                        is_lui || is_auipc || is_jal || is_jalr) && in_inst[11:7] != 5'd0;
         dec.mem_ctl = is_load ? ld_code : (is_store ? st_code : 4'b0000);
         if (is_load)
            dec.wb_ctl = 2'b01;
         else if (is_op || is_op32 || is_opimm || is_opimm32 || is_lui || is_auipc || is_jal || is_jalr)
            dec.wb_ctl = 2'b10;
         dec.branch  = is_branch;
         dec.jump    = is_jal || is_jalr;
      end
   end

   // ---------------- output register + skid buffer ----------------
   bundle_t o_q, s_q;
   logic    o_valid, s_valid, halted_q, ready_q;
   logic    o_valid_n, s_valid_n, halted_n;
   logic    load_o_from_s, load_o_from_in, load_s;
   logic    accept, drain;

   always_comb begin
      accept         = in_valid && ready_q && !flush;
      drain          = o_valid && out_ready;
      o_valid_n      = o_valid;
      s_valid_n      = s_valid;
      halted_n       = halted_q;
      load_o_from_s  = 1'b0;
      load_o_from_in = 1'b0;
      load_s         = 1'b0;
      if (flush) begin
         o_valid_n = 1'b0;
         s_valid_n = 1'b0;
         halted_n  = 1'b0;
      end else begin
         if (drain && o_q.is_ebreak)
            halted_n = 1'b1;
         // ready_q implies S is empty, so an accept never collides with an S->O move.
         if (!o_valid || out_ready) begin
            if (s_valid) begin
               load_o_from_s = 1'b1;
               o_valid_n     = 1'b1;
               s_valid_n     = 1'b0;
            end else if (accept) begin
               load_o_from_in = 1'b1;
               o_valid_n      = 1'b1;
            end else begin
               o_valid_n = 1'b0;
            end
         end else if (accept) begin
            load_s    = 1'b1;
            s_valid_n = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         o_q      <= '0;
         s_q      <= '0;
         o_valid  <= 1'b0;
         s_valid  <= 1'b0;
         halted_q <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         o_valid  <= o_valid_n;
         s_valid  <= s_valid_n;
         halted_q <= halted_n;
         ready_q  <= !s_valid_n && !halted_n;
         if (load_o_from_s)
            o_q <= s_q;
         else if (load_o_from_in)
            o_q <= dec;
         if (load_s)
            s_q <= dec;
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = o_valid;
   assign halted    = halted_q;
   assign out_pc    = o_q.pc;
   assign rs1_addr  = o_q.rs1;
   assign rs2_addr  = o_q.rs2;
   assign rd_addr   = o_q.rd;
   assign rs1_ena   = o_q.rs1_ena;
   assign rs2_ena   = o_q.rs2_ena;
   assign rd_ena    = o_q.rd_ena;
   assign imm       = o_q.imm;
   assign imm_ena   = o_q.imm_ena;
   assign alu_op    = o_q.alu_op;
   assign alu_word  = o_q.alu_word;
   assign alu_mul   = o_q.alu_mul;
   assign mem_ctl   = o_q.mem_ctl;
   assign wb_ctl    = o_q.wb_ctl;
   assign branch    = o_q.branch;
   assign jump      = o_q.jump;
   assign is_ebreak = o_q.is_ebreak;
   assign illegal   = o_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22051013_idu_pipe.sv
// Bench: an RV64+M instance (a_*) and an RV32-without-M instance (b_*) share one stimulus
// stream; a queue-based occupancy model and a class-level decoder predict every output.
`default_nettype none

module tb_ysyx_22051013_idu_pipe;

   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] ADDI   = 32'hFFF0_0093;
   localparam logic [31:0] LD     = 32'h0000_B103;
   localparam logic [31:0] MUL    = 32'h0220_81B3;
   localparam logic [6:0]  OPS [12] = '{7'h03, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                                        7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};

   typedef struct packed {
      logic [63:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic        rs1_ena, rs2_ena, rd_ena;
      logic [63:0] imm;
      logic        imm_ena;
      logic [3:0]  alu_op;
      logic        alu_word, alu_mul;
      logic [3:0]  mem_ctl;
      logic [1:0]  wb_ctl;
      logic        branch, jump, is_ebreak, illegal;
   } bun_t;

   typedef struct {
      logic [31:0] inst;
      logic [63:0] pc;
   } item_t;

   logic        clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [63:0] in_pc = '0;
   logic [31:0] in_inst = '0;

   logic        a_in_ready, a_out_valid, a_rs1_ena, a_rs2_ena, a_rd_ena, a_imm_ena, a_alu_word;
   logic        a_alu_mul, a_branch, a_jump, a_is_ebreak, a_illegal, a_halted;
   logic [63:0] a_out_pc, a_imm;
   logic [4:0]  a_rs1, a_rs2, a_rd;
   logic [3:0]  a_alu_op, a_mem_ctl;
   logic [1:0]  a_wb_ctl;

   logic        b_in_ready, b_out_valid, b_rs1_ena, b_rs2_ena, b_rd_ena, b_imm_ena, b_alu_word;
   logic        b_alu_mul, b_branch, b_jump, b_is_ebreak, b_illegal, b_halted;
   logic [63:0] b_out_pc;
   logic [31:0] b_imm;
   logic [4:0]  b_rs1, b_rs2, b_rd;
   logic [3:0]  b_alu_op, b_mem_ctl;
   logic [1:0]  b_wb_ctl;

   ysyx_22051013_idu_pipe #(.XLEN(64), .RV_M(1), .PC_W(64)) dut_a (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_pc(a_out_pc), .rs1_addr(a_rs1), .rs2_addr(a_rs2), .rd_addr(a_rd),
      .rs1_ena(a_rs1_ena), .rs2_ena(a_rs2_ena), .rd_ena(a_rd_ena), .imm(a_imm),
      .imm_ena(a_imm_ena), .alu_op(a_alu_op), .alu_word(a_alu_word), .alu_mul(a_alu_mul),
      .mem_ctl(a_mem_ctl), .wb_ctl(a_wb_ctl), .branch(a_branch), .jump(a_jump),
      .is_ebreak(a_is_ebreak), .illegal(a_illegal), .halted(a_halted));

   ysyx_22051013_idu_pipe #(.XLEN(32), .RV_M(0), .PC_W(64)) dut_b (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_pc(b_out_pc), .rs1_addr(b_rs1), .rs2_addr(b_rs2), .rd_addr(b_rd),
      .rs1_ena(b_rs1_ena), .rs2_ena(b_rs2_ena), .rd_ena(b_rd_ena), .imm(b_imm),
      .imm_ena(b_imm_ena), .alu_op(b_alu_op), .alu_word(b_alu_word), .alu_mul(b_alu_mul),
      .mem_ctl(b_mem_ctl), .wb_ctl(b_wb_ctl), .branch(b_branch), .jump(b_jump),
      .is_ebreak(b_is_ebreak), .illegal(b_illegal), .halted(b_halted));

   bun_t obs_a, obs_b;
   assign obs_a = {a_out_pc, a_rs1, a_rs2, a_rd, a_rs1_ena, a_rs2_ena, a_rd_ena, a_imm,
                   a_imm_ena, a_alu_op, a_alu_word, a_alu_mul, a_mem_ctl, a_wb_ctl,
                   a_branch, a_jump, a_is_ebreak, a_illegal};
   assign obs_b = {b_out_pc, b_rs1, b_rs2, b_rd, b_rs1_ena, b_rs2_ena, b_rd_ena, {32'b0, b_imm},
                   b_imm_ena, b_alu_op, b_alu_word, b_alu_mul, b_mem_ctl, b_wb_ctl,
                   b_branch, b_jump, b_is_ebreak, b_illegal};

   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   item_t q[$];
   bit    halted_m = 1'b0;

   task automatic chk(string tag, logic [191:0] obs, logic [191:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference decoder written from the instruction-class rules; mask selects the fields it defines.
   task automatic model(input logic [31:0] w, input logic [63:0] pc, input bit x64, input bit rvm,
                        output bun_t b, output bun_t m);
      logic [6:0]  op = w[6:0];
      logic [2:0]  f3 = w[14:12];
      bit          ld = op == 7'h03, oi = op == 7'h13, au = op == 7'h17, oi32 = op == 7'h1B;
      bit          st = op == 7'h23, rr = op == 7'h33, lui = op == 7'h37, rr32 = op == 7'h3B;
      bit          br = op == 7'h63, jalr = op == 7'h67, jal = op == 7'h6F, sys = op == 7'h73;
      bit          known = ld | oi | au | oi32 | st | rr | lui | rr32 | br | jalr | jal | sys;
      bit          mop = (rr | rr32) && w[31:25] == 7'b0000001;
      bit          bad;
      logic [3:0]  ldc [8] = '{4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0000};
      logic [3:0]  stc [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b0101};
      logic [12:0] bimm = {w[31], w[7], w[30:25], w[11:8], 1'b0};
      logic [20:0] jimm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
      logic [11:0] simm = {w[31:25], w[11:7]};
      logic [31:0] uimm = {w[31:12], 12'b0};
      bad = !known || (ld && (f3 == 7 || (!x64 && (f3 == 3 || f3 == 6))))
            || (st && (f3 > 3 || (!x64 && f3 == 3))) || (br && (f3 == 2 || f3 == 3))
            || (!x64 && (rr32 || oi32)) || (!x64 && oi && (f3 == 1 || f3 == 5) && w[25])
            || (!rvm && mop) || (sys && w != EBREAK);
      b = '0;
      b.pc = pc; b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7];
      b.illegal = bad;
      b.is_ebreak = (w == EBREAK);
      if (ld || oi || oi32 || jalr || sys) b.imm = 64'($signed(w[31:20]));
      if (st)         b.imm = 64'($signed(simm));
      if (br)         b.imm = 64'($signed(bimm));
      if (lui || au)  b.imm = 64'($signed(uimm));
      if (jal)        b.imm = 64'($signed(jimm));
      if (!x64)       b.imm[63:32] = '0;
      b.rs1_ena  = !(lui || au || jal || sys);
      b.rs2_ena  = rr || rr32 || br || st;
      b.imm_ena  = ld || st || oi || oi32;
      b.alu_word = rr32 || oi32;
      b.alu_mul  = mop && rvm;
      if (rr || rr32 || ((oi || oi32) && f3 == 5)) b.alu_op = {w[30], f3};
      else if (br || sys || oi || oi32)            b.alu_op = {1'b0, f3};
      if (!bad) begin
         b.rd_ena  = (ld || oi || oi32 || rr || rr32 || lui || au || jal || jalr) && w[11:7] != 0;
         b.mem_ctl = ld ? ldc[f3] : (st ? stc[f3[1:0]] : 4'b0000);
         b.wb_ctl  = ld ? 2'b01 : ((oi || oi32 || rr || rr32 || lui || au || jal || jalr) ? 2'b10 : 2'b00);
         b.branch  = br;
         b.jump    = jal || jalr;
      end
      m = '1;
      if (!(ld || st || oi || oi32 || rr || rr32 || br)) m.imm_ena = 1'b0;
      if (bad) begin
         m = '0;
         m.pc = '1; m.rs1 = '1; m.rs2 = '1; m.rd = '1; m.rd_ena = 1'b1; m.mem_ctl = '1;
         m.wb_ctl = '1; m.branch = 1'b1; m.jump = 1'b1; m.is_ebreak = 1'b1; m.illegal = 1'b1;
      end
   endtask

   task automatic check_state(string tag);
      bun_t e, m;
      bit   rdy = q.size() < 2 && !halted_m;
      chk({tag, ":a_out_valid"}, 192'(a_out_valid), 192'(q.size() > 0));
      chk({tag, ":b_out_valid"}, 192'(b_out_valid), 192'(q.size() > 0));
      chk({tag, ":a_in_ready"},  192'(a_in_ready),  192'(rdy));
      chk({tag, ":b_in_ready"},  192'(b_in_ready),  192'(rdy));
      chk({tag, ":a_halted"},    192'(a_halted),    192'(halted_m));
      chk({tag, ":b_halted"},    192'(b_halted),    192'(halted_m));
      if (q.size() > 0) begin
         model(q[0].inst, q[0].pc, 1'b1, 1'b1, e, m);
         chk({tag, ":a_bundle"}, 192'(obs_a & m), 192'(e & m));
         model(q[0].inst, q[0].pc, 1'b0, 1'b0, e, m);
         chk({tag, ":b_bundle"}, 192'(obs_b & m), 192'(e & m));
      end
   endtask

   // Drive one cycle at the falling edge, advance the model, then check at the next falling edge.
   task automatic step(string tag, bit iv, logic [31:0] w, logic [63:0] pc, bit ordy, bit fl);
      bit acc = iv && !fl && q.size() < 2 && !halted_m;
      bit drn = q.size() > 0 && ordy;
      in_valid = iv; in_inst = w; in_pc = pc; out_ready = ordy; flush = fl;
      if (fl) begin
         q.delete();
         halted_m = 1'b0;
      end else begin
         if (drn) begin
            if (q[0].inst == EBREAK) halted_m = 1'b1;
            q.delete(0);
         end
         if (acc) q.push_back('{w, pc});
      end
      @(negedge clk);
      check_state(tag);
   endtask

   function automatic logic [31:0] gen();
      logic [31:0] w = $urandom;
      int k = $urandom_range(0, 13);
      if (k < 12) w[6:0] = OPS[k];
      case ($urandom_range(0, 2))
         0: w[31:25] = 7'b0000001;
         1: w[31:25] = 7'b0000000;
         default: ;
      endcase
      if (w == EBREAK) w = 32'h0000_0013;
      return w;
   endfunction

   initial begin
      repeat (2) @(negedge clk);
      check_state("reset");
      chk("reset:a_bundle_zero", 192'(obs_a), '0);
      chk("reset:b_bundle_zero", 192'(obs_b), '0);
      rst = 1'b1;

      // addi x1,x0,-1 with explicit constants
      step("addi", 1'b1, ADDI, 64'h1000, 1'b1, 1'b0);
      chk("addi:a_imm", 192'(a_imm), 192'(64'hFFFF_FFFF_FFFF_FFFF));
      chk("addi:b_imm", 192'(b_imm), 192'(32'hFFFF_FFFF));
      chk("addi:a_ctl", 192'({a_rd, a_alu_op, a_wb_ctl, a_imm_ena}), 192'({5'd1, 4'b0000, 2'b10, 1'b1}));

      // ld on RV64 vs RV32
      step("ld", 1'b1, LD, 64'h1004, 1'b1, 1'b0);
      chk("ld:a_ctl", 192'({a_mem_ctl, a_wb_ctl, a_illegal}), 192'({4'b1100, 2'b01, 1'b0}));
      chk("ld:b_ctl", 192'({b_mem_ctl, b_rd_ena, b_illegal}), 192'({4'b0000, 1'b0, 1'b1}));

      // mul with and without M
      step("mul", 1'b1, MUL, 64'h1008, 1'b1, 1'b0);
      chk("mul:a_ctl", 192'({a_alu_mul, a_alu_op, a_illegal}), 192'({1'b1, 4'b0000, 1'b0}));
      chk("mul:b_illegal", 192'(b_illegal), 192'(1'b1));
      step("ecall", 1'b1, 32'h0000_0073, 64'h100C, 1'b1, 1'b0);
      step("drain0", 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

      // back-to-back with downstream stalled, then release
      step("bp0", 1'b1, 32'h0010_0113, 64'h2000, 1'b0, 1'b0);
      step("bp1", 1'b1, 32'h0020_0193, 64'h2004, 1'b0, 1'b0);
      step("bp2", 1'b1, 32'h0030_0213, 64'h2008, 1'b0, 1'b0);
      step("rel0", 1'b1, 32'h0030_0213, 64'h2008, 1'b1, 1'b0);
      step("rel1", 1'b1, 32'h0030_0213, 64'h2008, 1'b1, 1'b0);
      step("rel2", 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
      step("rel3", 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

      // ebreak leaves the stage -> halt; flush clears it
      step("ebrk", 1'b1, EBREAK, 64'h3000, 1'b1, 1'b0);
      step("halt0", 1'b1, ADDI, 64'h3004, 1'b1, 1'b0);
      step("halt1", 1'b1, ADDI, 64'h3008, 1'b0, 1'b0);
      step("halt2", 1'b1, ADDI, 64'h3008, 1'b1, 1'b0);
      step("halt3", 1'b1, ADDI, 64'h3008, 1'b1, 1'b0);
      step("unhalt", 1'b1, ADDI, 64'h3008, 1'b1, 1'b1);
      step("unhalt1", 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

      // flush with O and S full and a live input
      step("fill0", 1'b1, 32'h0050_0293, 64'h4000, 1'b0, 1'b0);
      step("fill1", 1'b1, 32'h0060_0313, 64'h4004, 1'b0, 1'b0);
      step("flush", 1'b1, 32'h0070_0393, 64'h4008, 1'b0, 1'b1);
      step("postfl", 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

      // randomized traffic with occasional flushes
      for (int i = 0; i < 400; i++)
         step("rnd", $urandom_range(0, 3) != 0, gen(), {32'h0, $urandom}, $urandom_range(0, 2) != 0,
              $urandom_range(0, 24) == 0);

      // asynchronous reset mid-stream
      step("pre_rst0", 1'b1, 32'h0080_0413, 64'h5000, 1'b0, 1'b0);
      step("pre_rst1", 1'b1, 32'h0090_0493, 64'h5004, 1'b0, 1'b0);
      #2 rst = 1'b0;
      #1;
      q.delete();
      halted_m = 1'b0;
      chk("arst:a_bundle_zero", 192'(obs_a), '0);
      chk("arst:b_bundle_zero", 192'(obs_b), '0);
      check_state("arst");
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      step("post_rst", 1'b1, ADDI, 64'h6000, 1'b1, 1'b0);
      step("post_rst1", 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
